// File: rtl/rect_cmd_sequencer_if.sv
// Bundled command, drawer and coordinate-output signals of rect_cmd_sequencer.
// The slave modport is the sequencer; the master modport is its surroundings.
interface rect_cmd_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_s_x;
    logic [31:0] cmd_s_y;
    logic [31:0] cmd_height;
    logic [31:0] cmd_width;
    logic        drw_start;
    logic [31:0] drw_s_x;
    logic [31:0] drw_s_y;
    logic [31:0] drw_height;
    logic [31:0] drw_width;
    logic [31:0] drw_out0;
    logic [31:0] drw_out1;
    logic        drw_done;
    logic [31:0] _out0;
    logic [31:0] _out1;
    logic        _valid;
    logic        busy;
    logic [15:0] jobs_done;

    modport slave (
        input  cmd_valid, cmd_s_x, cmd_s_y, cmd_height, cmd_width,
        input  drw_out0, drw_out1, drw_done,
        output cmd_ready, drw_start, drw_s_x, drw_s_y, drw_height, drw_width,
        output _out0, _out1, _valid, busy, jobs_done
    );

    modport master (
        output cmd_valid, cmd_s_x, cmd_s_y, cmd_height, cmd_width,
        output drw_out0, drw_out1, drw_done,
        input  cmd_ready, drw_start, drw_s_x, drw_s_y, drw_height, drw_width,
        input  _out0, _out1, _valid, busy, jobs_done
    );
endinterface

// File: rtl/rect_cmd_sequencer.sv
// Queues rectangle commands and runs them one at a time through an external
// draw_rectangle engine, forwarding its coordinates and counting completed jobs.
module rect_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                 _clock,
    input  logic                 _reset,
    rect_cmd_sequencer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO_C = {CW{1'b0}};

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_DROP   = 2'd3;

    logic [127:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic [1:0]    state_q, state_d;
    logic          drw_start_q, drw_start_d;
    logic [127:0]  args_q, args_d;
    logic [31:0]   out0_q, out0_d;
    logic [31:0]   out1_q, out1_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic [15:0]   jobs_done_q, jobs_done_d;

    logic          push_s;
    logic          pop_s;
    logic          coord_s;
    logic [127:0]  head_s;
    logic          head_zero_s;

    // Next-state logic for the command queue, job FSM and output registers.
    always_comb begin
        head_s      = mem_q[rd_ptr_q];
        head_zero_s = (head_s[63:32] == 32'd0) || (head_s[31:0] == 32'd0);
        push_s      = bus.cmd_valid && cmd_ready_q;
        pop_s       = 1'b0;
        state_d     = state_q;

        case (state_q)
            ST_IDLE: begin
                if (count_q != CNT_ZERO_C) begin
                    if (head_zero_s) begin
                        state_d = ST_DROP;
                    end else begin
                        state_d = ST_LAUNCH;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                pop_s   = 1'b1;
                state_d = ST_IDLE;
            end
            ST_LAUNCH: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.drw_done) begin
                    pop_s   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wr_ptr_d = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Ready looks only at the registered occupancy, so a pop never opens a slot the same cycle.
        cmd_ready_d = (count_d < DEPTH_C);

        if ((state_q == ST_IDLE) && (state_d == ST_LAUNCH)) begin
            args_d = head_s;
        end else begin
            args_d = args_q;
        end

        drw_start_d = (state_d == ST_LAUNCH);

        coord_s = (state_q == ST_RUN) && !bus.drw_done;
        valid_d = coord_s;
        if (coord_s) begin
            out0_d = bus.drw_out0;
            out1_d = bus.drw_out1;
        end else begin
            out0_d = out0_q;
            out1_d = out1_q;
        end

        jobs_done_d = pop_s ? (jobs_done_q + 16'd1) : jobs_done_q;
        busy_d      = (count_d != CNT_ZERO_C) || (state_d != ST_IDLE);
    end

    // Control and output registers; reset aborts any job and empties the queue.
    always_ff @(posedge _clock) begin
        if (_reset) begin
            wr_ptr_q    <= {PW{1'b0}};
            rd_ptr_q    <= {PW{1'b0}};
            count_q     <= CNT_ZERO_C;
            cmd_ready_q <= 1'b0;
            state_q     <= ST_IDLE;
            drw_start_q <= 1'b0;
            args_q      <= 128'd0;
            out0_q      <= 32'd0;
            out1_q      <= 32'd0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            jobs_done_q <= 16'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cmd_ready_q <= cmd_ready_d;
            state_q     <= state_d;
            drw_start_q <= drw_start_d;
            args_q      <= args_d;
            out0_q      <= out0_d;
            out1_q      <= out1_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            jobs_done_q <= jobs_done_d;
        end
    end

    // Command storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge _clock) begin
        if (push_s && !_reset) begin
            mem_q[wr_ptr_q] <= {bus.cmd_s_x, bus.cmd_s_y, bus.cmd_height, bus.cmd_width};
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.drw_start  = drw_start_q;
    assign bus.drw_s_x    = args_q[127:96];
    assign bus.drw_s_y    = args_q[95:64];
    assign bus.drw_height = args_q[63:32];
    assign bus.drw_width  = args_q[31:0];
    assign bus._out0      = out0_q;
    assign bus._out1      = out1_q;
    assign bus._valid     = valid_q;
    assign bus.busy       = busy_q;
    assign bus.jobs_done  = jobs_done_q;
endmodule

// File: doc/rect_cmd_sequencer.md
RECT_CMD_SEQUENCER -- requirements
Module: rect_cmd_sequencer

Interface
REQ-001 Port _clock  input  1  single clock; all state updates on rising edge.
REQ-002 Port _reset  input  1  synchronous, active-high reset, sampled on rising edge of _clock.
REQ-003 Port cmd_valid  input  1  rectangle command present on cmd_* this cycle.
REQ-004 Port cmd_ready  output  1  command queue can accept; push occurs when cmd_valid && cmd_ready.
REQ-005 Ports cmd_s_x, cmd_s_y, cmd_height, cmd_width  input  32 each  command arguments, unsigned.
REQ-006 Port drw_start  output  1  one-cycle start pulse to draw_rectangle _start.
REQ-007 Ports drw_s_x, drw_s_y, drw_height, drw_width  output  32 each  arguments to draw_rectangle.
REQ-008 Ports drw_out0, drw_out1  input  32 each  coordinate pair from draw_rectangle _out0/_out1.
REQ-009 Port drw_done  input  1  draw_rectangle _done.
REQ-010 Ports _out0, _out1  output  32 each  forwarded coordinate pair.
REQ-011 Port _valid  output  1  _out0/_out1 carry a coordinate this cycle.
REQ-012 Port busy  output  1  queue non-empty or job in progress.
REQ-013 Port jobs_done  output  16  completed-command count, including dropped zero-size commands.
REQ-014 Parameter DEPTH, default 4, command queue depth (power of two, >= 2).

Function
REQ-015 Queue: FIFO of DEPTH 128-bit entries {s_x, s_y, height, width}; cmd_ready SHALL be 1 iff occupancy < DEPTH, registered, independent of same-cycle pop.
REQ-016 Push when cmd_valid && cmd_ready; push while full SHALL be ignored, with no state change.
REQ-017 Simultaneous push and pop SHALL leave occupancy unchanged; read/write pointers wrap modulo DEPTH.
REQ-018 FSM states: IDLE, LAUNCH, RUN, DROP.
REQ-019 IDLE: if queue empty, stay; if head height==0 or width==0, go to DROP; else go to LAUNCH.
REQ-020 DROP: pop head, increment jobs_done, no drw_start, return to IDLE (1 cycle).
REQ-021 LAUNCH: drw_start=1 for exactly this cycle; go to RUN next cycle.
REQ-022 drw_s_x/s_y/height/width SHALL equal the queue head from LAUNCH entry through RUN exit, stable; value is don't-care otherwise but SHALL not change while in RUN.
REQ-023 RUN: each cycle with drw_done==0 is a coordinate; when drw_done==1, pop head, increment jobs_done, go to IDLE.
REQ-024 _out0/_out1/_valid SHALL be registered: _valid = (state==RUN && !drw_done) delayed one cycle; _out* = drw_out* of that cycle; _out* hold last value when _valid==0.
REQ-025 Back-to-back jobs: minimum one IDLE cycle between RUN exit and next LAUNCH; no coordinate from job N+1 appears before the last of job N.
REQ-026 jobs_done: 16-bit, wraps 0xFFFF -> 0x0000.
REQ-027 busy = (occupancy != 0) || (state != IDLE).
REQ-028 No downstream backpressure; coordinates are never stalled or dropped.

Reset
REQ-029 On _reset=1: state=IDLE, queue emptied, cmd_ready=0 during reset then 1 the cycle after deassertion, drw_start=0, _valid=0, _out0=_out1=0, jobs_done=0, busy=0, drw_* args=0.
REQ-030 Reset mid-RUN SHALL abort the job without incrementing jobs_done; the queued command is discarded; no _valid in the cycle after reset.
REQ-031 Pushes presented while _reset=1 SHALL be ignored.

Verification
REQ-032 Single job (1,2,3,4), bench drawer emits 5 pairs then drw_done -> exactly one drw_start, drw_* = 1,2,3,4, 5 _valid pulses matching pairs 1 cycle late, jobs_done=1, busy=0.
REQ-033 Push 5 commands back-to-back with DEPTH=4 while drawer stalls (drw_done=0, no LAUNCH yet) -> cmd_ready=0 after 4th push, 5th ignored; 4 jobs complete in push order, jobs_done=4.
REQ-034 Zero size: push (0,0,0,4) then (0,0,2,2) -> first DROPped with no drw_start, jobs_done=1; second launches, jobs_done=2.
REQ-035 Push during full-queue pop cycle -> push ignored (registered ready), occupancy DEPTH-1 afterwards.
REQ-036 Assert _reset in 3rd RUN cycle of job (5,5,2,2) with 2 commands queued -> next cycle all outputs at reset values, jobs_done=0, busy=0.
REQ-037 Preload jobs_done to 0xFFFF via 65535 drops, then one more job -> jobs_done=0x0000.
